// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and direction type for the counter and future Gray-pointer sync blocks.
// Functions work on MaxWidth bits; callers zero-extend their value in and truncate the result.
package gray_pkg;

  localparam int unsigned MaxWidth = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB. Zero upper bits contribute nothing, so narrower values are safe.
  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g);
    logic [MaxWidth-1:0] b;
    b[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_ld.sv
// Registered up/down Gray counter with sync clear and binary/Gray load.
// Binary and Gray registers are written from one next-state value so they never disagree.
module gray_counter_ld
  import gray_pkg::*;
#(
  parameter int unsigned     WIDTH     = 4,
  parameter bit              WRAP_MODE = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MaxVal = '1;
  localparam logic [WIDTH-1:0] ResetGray = WIDTH'(bin2gray(MaxWidth'(RESET_VAL)));

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic             sat_d;
  dir_e             dir;

  assign dir = dir_e'(up);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_gray ? WIDTH'(gray2bin(MaxWidth'(load_val))) : load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (bin_q == MaxVal) begin
          if (WRAP_MODE) begin
            bin_d  = '0;
            wrap_d = 1'b1;
          end else begin
            sat_d = 1'b1;
          end
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end else begin
        if (bin_q == '0) begin
          if (WRAP_MODE) begin
            bin_d  = MaxVal;
            wrap_d = 1'b1;
          end else begin
            sat_d = 1'b1;
          end
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end
    end
    gray_d = WIDTH'(bin2gray(MaxWidth'(bin_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RESET_VAL;
      gray_q <= ResetGray;
      wrap   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap   <= wrap_d;
      sat    <= sat_d;
    end
  end

  assign at_max = (bin_q == MaxVal);
  assign at_min = (bin_q == '0);

endmodule
